wb_arbiter: RTL and testbench
=============================

WB_ARBITER -- requirements
Module: wb_arbiter

Interface
REQ-001 The block SHALL use one clock and an asynchronous, active-high reset, with ports named clk and rst.
REQ-002 The ports SHALL be:
- clk, input, 1: rising-edge clock.
- rst, input, 1: asynchronous active-high reset.
- a_valid, input, 1: ALU writeback request.
- a_ready, output, 1: ALU request accepted this cycle.
- a_reg, input, 5: ALU destination register.
- a_dat, input, 32: ALU result.
- b_valid, input, 1: load-unit writeback request.
- b_ready, output, 1: load-unit request accepted this cycle.
- b_reg, input, 5: load destination register.
- b_dat, input, 32: load data.
- write, output, 1: register-file write enable.
- w_reg, output, 5: register-file write index.
- w_dat, output, 32: register-file write data.
- iss_valid, input, 1: an instruction with a destination is issuing.
- iss_reg, input, 5: destination of the issuing instruction.
- chk_reg0, input, 5: source operand 0 of the issuing instruction.
- chk_reg1, input, 5: source operand 1 of the issuing instruction.
- stall, output, 1: hazard; issue SHALL be held.
- busy, output, 32: pending-write scoreboard.

Function
REQ-003 At most one request SHALL be accepted per cycle. A request is accepted when valid and ready are both 1 at a rising edge.
REQ-004 a_ready and b_ready SHALL be combinational from the valids and the arbitration state, and SHALL never both be 1.
REQ-005 A ready SHALL be 1 only while its own valid is 1. The sole valid requester SHALL always be granted.
REQ-006 A requester SHALL hold valid, reg and dat stable until accepted.
REQ-007 When both requests are valid, the winner SHALL be selected as given in REQ-019 and REQ-020.
REQ-008 On an accepted request with reg != 0, write, w_reg and w_dat SHALL be registered at the next edge, giving 1-cycle latency from acceptance to write=1. write SHALL be 1 for exactly one cycle per accepted request.
REQ-009 An accepted request with reg == 0 SHALL be consumed and SHALL leave write at 0.
REQ-010 When no request is accepted, write SHALL be 0 at the next edge. w_reg and w_dat SHALL then hold their previous values.
REQ-011 Back-to-back acceptances SHALL produce write=1 on consecutive cycles, with no bubble.
REQ-012 stall SHALL be 1 when any of the following holds:
- busy[chk_reg0] and chk_reg0 != 0;
- busy[chk_reg1] and chk_reg1 != 0;
- iss_valid and busy[iss_reg] and iss_reg != 0.
REQ-013 stall SHALL be combinational.
REQ-014 On each edge where iss_valid=1, stall=0 and iss_reg != 0, busy[iss_reg] SHALL be set.
REQ-015 On each edge where write=1, busy[w_reg] SHALL be cleared. The register file commits on the same edge.
REQ-016 If a set and a clear hit the same index on the same edge, the set SHALL win.
REQ-017 busy[0] SHALL always be 0.

Reset
REQ-018 While rst=1, asynchronously:
- write=0, w_reg=0, w_dat=0;
- busy=0;
- the round-robin pointer SHALL favour A.
An in-flight registered write SHALL be dropped. Requesters SHALL re-present their requests after rst falls.

Configuration
REQ-019 With WB_ARBITER_RR_EN defined, arbitration SHALL be round-robin:
- when both are valid, the requester not granted most recently SHALL win;
- the pointer SHALL update only on an acceptance.
REQ-020 Without WB_ARBITER_RR_EN, arbitration SHALL be fixed priority, and B (load) SHALL always beat A.

Verification
REQ-021 The bench SHALL cover the following directed scenarios:
- Single request: rst pulse, then a_valid=1, a_reg=5, a_dat=0xDEADBEEF for 1 cycle -> a_ready=1 that cycle; next cycle write=1, w_reg=5, w_dat=0xDEADBEEF; the cycle after, write=0.
- Contention: a_valid=b_valid=1 held for 4 cycles, a_reg=1, b_reg=2 -> fixed priority: b_ready=1 for all 4 cycles; RR: grants alternate A, B, A, B, and write=1 on 4 consecutive cycles.
- Register zero: b_valid=1, b_reg=0, b_dat=0x1234 -> b_ready=1; write stays 0; busy stays 0.
- Scoreboard: iss_valid=1, iss_reg=7 -> busy[7]=1; then chk_reg0=7 -> stall=1; then a_valid=1, a_reg=7 -> after the write=1 edge, busy[7]=0 and stall=0.
- Simultaneous set and clear: issue of reg 3 on the same edge as write=1, w_reg=3 -> busy[3]=1 afterwards.
- Reset mid-operation: rst asserted while write=1 and busy=0x00000088 -> write=0 and busy=0 immediately, before the next clk edge.

Source files
------------

// File: rtl/wb_arbiter.sv
// Writeback arbiter: merges ALU and load-unit results into one register-file write
// port and tracks pending destinations. Define WB_ARBITER_RR_EN for round-robin arbitration.
module wb_arbiter (
  input  logic        clk,
  input  logic        rst,
  input  logic        a_valid,
  output logic        a_ready,
  input  logic [4:0]  a_reg,
  input  logic [31:0] a_dat,
  input  logic        b_valid,
  output logic        b_ready,
  input  logic [4:0]  b_reg,
  input  logic [31:0] b_dat,
  output logic        write,
  output logic [4:0]  w_reg,
  output logic [31:0] w_dat,
  input  logic        iss_valid,
  input  logic [4:0]  iss_reg,
  input  logic [4:0]  chk_reg0,
  input  logic [4:0]  chk_reg1,
  output logic        stall,
  output logic [31:0] busy
);

  logic        w_grant_a;
  logic        w_grant_b;
  logic        w_accept;
  logic        w_commit;
  logic        w_set;
  logic [4:0]  w_sel_reg;
  logic [31:0] w_sel_dat;
  logic [31:0] w_busy_next;
  logic [31:0] r_busy;

`ifdef WB_ARBITER_RR_EN
  // r_prefer_a is 1 when B was granted most recently (or after reset).
  logic r_prefer_a;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_prefer_a <= 1'b1;
    end else if (w_accept) begin
      r_prefer_a <= w_grant_b;
    end
  end

  assign w_grant_a = a_valid && (!b_valid || r_prefer_a);
`else
  assign w_grant_a = a_valid && !b_valid;
`endif

  assign w_grant_b = b_valid && !w_grant_a;
  assign w_accept  = w_grant_a || w_grant_b;
  assign w_sel_reg = w_grant_a ? a_reg : b_reg;
  assign w_sel_dat = w_grant_a ? a_dat : b_dat;
  // Writes to r0 are accepted but never reach the register file.
  assign w_commit  = w_accept && (w_sel_reg != 5'd0);

  assign a_ready = w_grant_a;
  assign b_ready = w_grant_b;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      write <= 1'b0;
      w_reg <= 5'd0;
      w_dat <= 32'd0;
    end else begin
      write <= w_commit;
      if (w_commit) begin
        w_reg <= w_sel_reg;
        w_dat <= w_sel_dat;
      end
    end
  end

  assign stall = (r_busy[chk_reg0] && (chk_reg0 != 5'd0))
              || (r_busy[chk_reg1] && (chk_reg1 != 5'd0))
              || (iss_valid && r_busy[iss_reg] && (iss_reg != 5'd0));

  assign w_set = iss_valid && !stall && (iss_reg != 5'd0);

  // Clear first, then set, so a same-edge issue of the retiring register stays busy.
  always_comb begin
    w_busy_next = r_busy;
    if (write) begin
      w_busy_next[w_reg] = 1'b0;
    end
    if (w_set) begin
      w_busy_next[iss_reg] = 1'b1;
    end
    w_busy_next[0] = 1'b0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_busy <= 32'd0;
    end else begin
      r_busy <= w_busy_next;
    end
  end

  assign busy = r_busy;

endmodule

// File: tb/tb_wb_arbiter.sv
// Self-checking bench for wb_arbiter: directed scenarios followed by random
// traffic compared against a behavioural model of the writeback rules.
module tb_wb_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        a_valid, b_valid, iss_valid;
  logic        a_ready, b_ready, write, stall;
  logic [4:0]  a_reg, b_reg, w_reg, iss_reg, chk_reg0, chk_reg1;
  logic [31:0] a_dat, b_dat, w_dat, busy;

  int n_pass  = 0;
  int n_total = 0;

`ifdef WB_ARBITER_RR_EN
  localparam bit RR = 1'b1;
`else
  localparam bit RR = 1'b0;
`endif

  // Behavioural model state.
  bit          m_busy [32];
  bit          m_write;
  logic [4:0]  m_wreg;
  logic [31:0] m_wdat;
  bit          m_last_a;   // most recent grant went to A
  bit          exp_ga, exp_gb, exp_stall;

  wb_arbiter dut (
    .clk(clk), .rst(rst),
    .a_valid(a_valid), .a_ready(a_ready), .a_reg(a_reg), .a_dat(a_dat),
    .b_valid(b_valid), .b_ready(b_ready), .b_reg(b_reg), .b_dat(b_dat),
    .write(write), .w_reg(w_reg), .w_dat(w_dat),
    .iss_valid(iss_valid), .iss_reg(iss_reg),
    .chk_reg0(chk_reg0), .chk_reg1(chk_reg1),
    .stall(stall), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) begin
      n_pass++;
    end else begin
      $error("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] model_busy_vec();
    logic [31:0] v;
    for (int i = 0; i < 32; i++) v[i] = m_busy[i];
    return v;
  endfunction

  function automatic bit model_stall();
    return (chk_reg0 != 0 && m_busy[chk_reg0])
        || (chk_reg1 != 0 && m_busy[chk_reg1])
        || (iss_valid && iss_reg != 0 && m_busy[iss_reg]);
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 32; i++) m_busy[i] = 1'b0;
    m_write  = 1'b0;
    m_wreg   = 5'd0;
    m_wdat   = 32'd0;
    m_last_a = 1'b0;
  endtask

  task automatic idle();
    a_valid = 0; a_reg = 0; a_dat = 0;
    b_valid = 0; b_reg = 0; b_dat = 0;
    iss_valid = 0; iss_reg = 0; chk_reg0 = 0; chk_reg1 = 0;
  endtask

  // One clock cycle: called shortly after a rising edge with inputs already driven.
  task automatic cyc();
    logic [4:0]  sel_reg;
    logic [31:0] sel_dat;
    #4;
    exp_ga    = a_valid && (!b_valid || (RR && !m_last_a));
    exp_gb    = b_valid && !exp_ga;
    exp_stall = model_stall();
    check("a_ready", a_ready, exp_ga);
    check("b_ready", b_ready, exp_gb);
    check("stall", stall, exp_stall);
    @(posedge clk);
    if (m_write) m_busy[m_wreg] = 1'b0;
    if (iss_valid && !exp_stall && iss_reg != 0) m_busy[iss_reg] = 1'b1;
    m_write = 1'b0;
    if (exp_ga || exp_gb) begin
      sel_reg  = exp_ga ? a_reg : b_reg;
      sel_dat  = exp_ga ? a_dat : b_dat;
      m_last_a = exp_ga;
      $display("accept %s reg=%0d dat=%h", exp_ga ? "A" : "B", sel_reg, sel_dat);
      if (sel_reg != 0) begin
        m_write = 1'b1;
        m_wreg  = sel_reg;
        m_wdat  = sel_dat;
      end
    end
    #1;
    check("write", write, m_write);
    check("w_reg", w_reg, m_wreg);
    check("w_dat", w_dat, m_wdat);
    check("busy", busy, model_busy_vec());
  endtask

  task automatic do_reset();
    rst = 1'b1;
    #2;
    model_reset();
    check("rst_write", write, 32'd0);
    check("rst_busy", busy, 32'd0);
    check("rst_w_reg", w_reg, 32'd0);
    check("rst_w_dat", w_dat, 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    idle();
  endtask

  initial begin
    idle();
    rst = 1'b1;
    do_reset();

    // Single request from A.
    a_valid = 1; a_reg = 5; a_dat = 32'hDEADBEEF;
    #1 check("s1_a_ready", a_ready, 1);
    cyc();
    idle();
    check("s1_write", write, 1);
    check("s1_w_reg", w_reg, 5);
    check("s1_w_dat", w_dat, 32'hDEADBEEF);
    cyc();
    check("s1_write_off", write, 0);

    // Contention for four cycles.
    do_reset();
    a_valid = 1; a_reg = 1; a_dat = 32'hAAAA0001;
    b_valid = 1; b_reg = 2; b_dat = 32'hBBBB0002;
    for (int i = 0; i < 4; i++) begin
      #1;
      check("ct_a_ready", a_ready, RR && (i % 2 == 0));
      check("ct_b_ready", b_ready, !(RR && (i % 2 == 0)));
      cyc();
      check("ct_write", write, 1);
      check("ct_w_reg", w_reg, (RR && (i % 2 == 0)) ? 1 : 2);
    end
    idle();
    cyc();

    // Register zero is consumed without a write.
    do_reset();
    b_valid = 1; b_reg = 0; b_dat = 32'h1234;
    #1 check("r0_b_ready", b_ready, 1);
    cyc();
    idle();
    check("r0_write", write, 0);
    check("r0_busy", busy, 0);
    cyc();
    check("r0_write2", write, 0);

    // Scoreboard set, hazard, clear by writeback.
    iss_valid = 1; iss_reg = 7;
    cyc();
    check("sb_busy7_set", busy[7], 1);
    iss_valid = 0; chk_reg0 = 7;
    #1 check("sb_stall_on", stall, 1);
    cyc();
    a_valid = 1; a_reg = 7; a_dat = 32'h77777777;
    cyc();
    a_valid = 0;
    cyc();
    check("sb_busy7_clr", busy[7], 0);
    check("sb_stall_off", stall, 0);

    // Issue and writeback of reg 3 on the same edge: set wins.
    chk_reg0 = 0;
    a_valid = 1; a_reg = 3; a_dat = 32'h33333333;
    cyc();
    check("sc_write", write, 1);
    check("sc_w_reg", w_reg, 3);
    a_valid = 0; iss_valid = 1; iss_reg = 3;
    cyc();
    check("sc_busy3", busy[3], 1);

    // Reset while a write is in flight and busy=0x88.
    iss_valid = 1; iss_reg = 7;
    a_valid = 1; a_reg = 5; a_dat = 32'h55555555;
    cyc();
    idle();
    check("mr_write_pre", write, 1);
    check("mr_busy_pre", busy, 32'h00000088);
    do_reset();

    // Random traffic against the model; requesters hold until accepted.
    for (int i = 0; i < 600; i++) begin
      if (i == 300) do_reset();
      if (!a_valid && ($urandom % 3 == 0)) begin
        a_valid = 1; a_reg = 5'($urandom_range(0, 7)); a_dat = $urandom;
      end
      if (!b_valid && ($urandom % 3 == 0)) begin
        b_valid = 1; b_reg = 5'($urandom_range(0, 7)); b_dat = $urandom;
      end
      iss_valid = 1'($urandom % 2);
      iss_reg   = 5'($urandom_range(0, 7));
      chk_reg0  = 5'($urandom_range(0, 7));
      chk_reg1  = 5'($urandom_range(0, 7));
      cyc();
      if (exp_ga) a_valid = 0;
      if (exp_gb) b_valid = 0;
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
